// File: rtl/fp_add_normalize.sv
// fp_add_normalize
//   Post-add normalizer for the single-precision FP adder. Takes the raw
//   {sign, exponent, 25-bit significand sum} from the mantissa adder,
//   normalizes it one left shift per cycle, truncates, and packs an
//   IEEE-754 word. One operation in flight; valid/ready on both sides.
//
// Ports
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  operand handshake (ready only while idle)
//   in_sign, in_exp      result sign and common exponent after alignment
//   in_mant              raw sum: [MAN_W+1]=carry, [MAN_W]=hidden, rest=fraction
//   out_valid/out_ready  result handshake
//   out_num              packed {sign, exp, frac}
//   out_ovf, out_unf     overflow-to-infinity / underflow-flushed-to-zero flags
module fp_add_normalize #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [EXP_W-1:0]       in_exp,
    input  logic [MAN_W+1:0]       in_mant,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_num,
    output logic                   out_ovf,
    output logic                   out_unf
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_PACK  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    logic [2:0]             r_state;
    logic                   r_sign;
    logic [EXP_W-1:0]       r_exp;
    logic [MAN_W+1:0]       r_mant;
    logic [EXP_W+MAN_W:0]   r_res;
    logic                   r_ovf;
    logic                   r_unf;

    logic [EXP_W-1:0]       w_exp_inc;
    logic [EXP_W-1:0]       w_exp_dec;
    logic [MAN_W+1:0]       w_mant_shl;
    logic [EXP_W+MAN_W:0]   w_flush;

    assign w_exp_inc  = r_exp + EXP_ONE;
    assign w_exp_dec  = r_exp - EXP_ONE;
    assign w_mant_shl = {r_mant[MAN_W:0], 1'b0};
    assign w_flush    = {r_sign, {(EXP_W+MAN_W){1'b0}}};

    assign in_ready = (r_state == S_IDLE) && !rst;

    // Result word is assembled in r_res during CHECK/SHIFT; PACK copies it
    // to the outputs so out_num/flags only move when a result is presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sign    <= 1'b0;
            r_exp     <= '0;
            r_mant    <= '0;
            r_res     <= '0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            out_valid <= 1'b0;
            out_num   <= '0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sign  <= in_sign;
                        r_exp   <= in_exp;
                        r_mant  <= in_mant;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_ovf   <= 1'b0;
                    r_unf   <= 1'b0;
                    r_state <= S_PACK;
                    if (r_exp == EXP_MAX) begin
                        r_res <= {r_sign, EXP_MAX, r_mant[MAN_W-1:0]};
                    end else if (r_mant == '0) begin
                        r_res <= '0;                 // exact zero is always +0
                    end else if (r_exp == '0) begin
                        r_res <= w_flush;
                        r_unf <= 1'b1;
                    end else if (r_mant[MAN_W+1]) begin
                        // carry out: renormalize right by one, LSB truncated
                        if (w_exp_inc == EXP_MAX) begin
                            r_res <= {r_sign, EXP_MAX, {MAN_W{1'b0}}};
                            r_ovf <= 1'b1;
                        end else begin
                            r_res <= {r_sign, w_exp_inc, r_mant[MAN_W:1]};
                        end
                    end else if (r_mant[MAN_W]) begin
                        r_res <= {r_sign, r_exp, r_mant[MAN_W-1:0]};
                    end else begin
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // exp cannot go below 1 here; hitting 1 with no hidden bit
                    // would need a denormal, which is flushed instead.
                    if (r_exp == EXP_ONE) begin
                        r_res   <= w_flush;
                        r_unf   <= 1'b1;
                        r_state <= S_PACK;
                    end else begin
                        r_mant <= w_mant_shl;
                        r_exp  <= w_exp_dec;
                        if (w_mant_shl[MAN_W]) begin
                            r_res   <= {r_sign, w_exp_dec, w_mant_shl[MAN_W-1:0]};
                            r_state <= S_PACK;
                        end
                    end
                end
                S_PACK: begin
                    out_num   <= r_res;
                    out_ovf   <= r_ovf;
                    out_unf   <= r_unf;
                    out_valid <= 1'b1;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
